// File: rtl/mips_pkg.sv
// Shared MIPS control encodings: opcodes, ALUOp, mux selects and the
// multicycle main-control state enum.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // ALUOp is consumed by the ALU control decoder alongside funct.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUSRCB_REG     = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB,
        S_MEM_WRITE, S_EXECUTE, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_EXEC, S_ADDI_WB
    } state_t;

    function automatic logic is_legal_opcode(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mc_main_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/
// writeback, drives datapath controls, flags illegal opcodes, counts retires.
module mc_main_control
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             IRWrite,
    output logic             ALUSrcA,
    output logic             RegWrite,
    output logic             RegDst,
    output logic [1:0]       PCSource,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    state_t state;
    state_t state_nxt;
    logic   retire;
    logic   decode_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            illegal_op  <= 1'b0;
            instr_count <= '0;
        end else begin
            state      <= state_nxt;
            illegal_op <= decode_illegal;
            if (retire) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      state_nxt = S_FETCH;
            S_FETCH:     if (mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
                    OP_RTYPE:     state_nxt = S_EXECUTE;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_J:         state_nxt = S_JUMP;
                    OP_ADDI:      state_nxt = S_ADDI_EXEC;
                    default:      state_nxt = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  state_nxt = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (mem_ready) state_nxt = S_MEM_WB;
            S_MEM_WB:    state_nxt = S_FETCH;
            S_MEM_WRITE: if (mem_ready) state_nxt = S_FETCH;
            S_EXECUTE:   state_nxt = S_R_WB;
            S_R_WB:      state_nxt = S_FETCH;
            S_BRANCH:    state_nxt = S_FETCH;
            S_JUMP:      state_nxt = S_FETCH;
            S_ADDI_EXEC: state_nxt = S_ADDI_WB;
            S_ADDI_WB:   state_nxt = S_FETCH;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Only completed instructions retire; the DECODE->FETCH illegal path never does.
    assign retire = (state_nxt == S_FETCH) &&
                    (state inside {S_MEM_WB, S_MEM_WRITE, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB});
    assign decode_illegal = (state == S_DECODE) && !is_legal_opcode(opcode);

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        PCSource    = PCSRC_ALU;
        ALUSrcB     = ALUSRCB_REG;
        ALUOp       = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = ALUSRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE:    ALUSrcB = ALUSRCB_IMM_SH2;
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = ALUSRCB_IMM;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
            end
            S_R_WB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            S_ADDI_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = ALUSRCB_IMM;
            end
            S_ADDI_WB:   RegWrite = 1'b1;
            default: ;
        endcase
    end

endmodule
